// File: rtl/mem_pkg.sv
// Shared encodings for the memory stage: result select, access size codes,
// handshake FSM states and the packed execute-to-memory pipeline register.
package mem_pkg;

    localparam int WORD_W = 32;

    localparam logic [1:0] RESULT_ALU = 2'b00;
    localparam logic [1:0] RESULT_MEM = 2'b01;
    localparam logic [1:0] RESULT_PC4 = 2'b10;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {IDLE, WAIT} mem_state_t;

    typedef struct packed {
        logic              regwrite;
        logic [1:0]        resultsrc;
        logic              memwrite;
        logic [2:0]        funct3;
        logic [WORD_W-1:0] aluresult;
        logic [WORD_W-1:0] writedata;
        logic [WORD_W-1:0] pcplus4;
        logic [4:0]        rd;
    } mreg_t;

endpackage

// File: rtl/load_store_align.sv
// Byte-lane steering for stores, extract/extend for loads, misalignment check.
// Purely combinational; no state and no backpressure of its own.
module load_store_align
    import mem_pkg::*;
(
    input  logic [2:0]        funct3,
    input  logic [1:0]        offset,
    input  logic              memop,
    input  logic              is_load,
    input  logic [WORD_W-1:0] store_data,
    input  logic [WORD_W-1:0] rdata,
    output logic [3:0]        be,
    output logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] load_data,
    output logic              misaligned
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        unsigned_ld;

    assign byte_sel    = rdata[{offset, 3'b000} +: 8];
    assign half_sel    = offset[1] ? rdata[31:16] : rdata[15:0];
    assign unsigned_ld = funct3[2];

    always_comb begin
        be         = 4'b0000;
        wdata      = store_data;
        load_data  = '0;
        misaligned = 1'b0;
        if (funct3[1:0] == F3_B[1:0]) begin
            be        = 4'b0001 << offset;
            wdata     = {4{store_data[7:0]}};
            load_data = unsigned_ld ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
        end else if (funct3[1:0] == F3_H[1:0]) begin
            be         = offset[1] ? 4'b1100 : 4'b0011;
            wdata      = {2{store_data[15:0]}};
            load_data  = unsigned_ld ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
            misaligned = offset[0];
        end else begin
            be         = 4'b1111;
            load_data  = rdata;
            misaligned = (offset != 2'b00);
        end
        // Non-memory instructions touch no lanes and never flag misalignment.
        if (!memop) begin
            be         = 4'b0000;
            misaligned = 1'b0;
        end
        if (!is_load) begin
            load_data = '0;
        end
    end

endmodule

// File: rtl/memory_stage.sv
// Memory stage: E->M register, valid/ack data-memory FSM, load/store alignment.
// Latency 1 cycle plus memory wait cycles; BusyM holds M and stalls upstream until ack.
module memory_stage
    import mem_pkg::*;
#(
    parameter int word_width = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  RegWriteE,
    input  logic [1:0]            ResultSrcE,
    input  logic                  MemWriteE,
    input  logic [2:0]            Funct3E,
    input  logic [word_width-1:0] ALUResultE,
    input  logic [word_width-1:0] WriteDataE,
    input  logic [word_width-1:0] PCPlus4E,
    input  logic [4:0]            RdE,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [word_width-1:0] dmem_addr,
    output logic [word_width-1:0] dmem_wdata,
    output logic [3:0]            dmem_be,
    input  logic [word_width-1:0] dmem_rdata,
    input  logic                  dmem_ack,
    output logic                  RegWriteM,
    output logic [1:0]            ResultSrcM,
    output logic [word_width-1:0] ALUResultM,
    output logic [word_width-1:0] PCPlus4M,
    output logic [4:0]            RdM,
    output logic [word_width-1:0] ReadDataM,
    output logic                  BusyM,
    output logic                  MisalignedM
);

    mreg_t      m_q;
    mreg_t      m_d;
    mem_state_t state;
    logic       memop;
    logic       is_load;
    logic       misaligned;
    logic       access;

    assign m_d = '{regwrite:  RegWriteE,
                   resultsrc: ResultSrcE,
                   memwrite:  MemWriteE,
                   funct3:    Funct3E,
                   aluresult: ALUResultE,
                   writedata: WriteDataE,
                   pcplus4:   PCPlus4E,
                   rd:        RdE};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_q <= '0;
        end else if (!BusyM) begin
            m_q <= m_d;
        end
    end

    assign is_load = (m_q.resultsrc == RESULT_MEM);
    assign memop   = m_q.memwrite | is_load;
    assign access  = memop & ~misaligned;

    load_store_align u_align (
        .funct3     (m_q.funct3),
        .offset     (m_q.aluresult[1:0]),
        .memop      (memop),
        .is_load    (is_load),
        .store_data (m_q.writedata),
        .rdata      (dmem_rdata),
        .be         (dmem_be),
        .wdata      (dmem_wdata),
        .load_data  (ReadDataM),
        .misaligned (misaligned)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (access && !dmem_ack) state <= WAIT;
                WAIT:    if (dmem_ack) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // M is frozen while in WAIT, so the request fields stay stable until ack.
    assign dmem_req  = (state == WAIT) | access;
    assign dmem_we   = m_q.memwrite & access;
    assign dmem_addr = {m_q.aluresult[word_width-1:2], 2'b00};
    assign BusyM     = dmem_req & ~dmem_ack;

    // Writeback samples every cycle, so a stalled or faulting instruction must not write.
    assign RegWriteM   = m_q.regwrite & ~misaligned & ~BusyM;
    assign ResultSrcM  = m_q.resultsrc;
    assign ALUResultM  = m_q.aluresult;
    assign PCPlus4M    = m_q.pcplus4;
    assign RdM         = m_q.rd;
    assign MisalignedM = misaligned;

endmodule

// File: tb/tb_memory_stage.sv
// Directed and randomized checks of memory_stage against a behavioural model.
module tb_memory_stage;

    logic        clk;
    logic        reset;
    logic        RegWriteE;
    logic [1:0]  ResultSrcE;
    logic        MemWriteE;
    logic [2:0]  Funct3E;
    logic [31:0] ALUResultE;
    logic [31:0] WriteDataE;
    logic [31:0] PCPlus4E;
    logic [4:0]  RdE;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic        RegWriteM;
    logic [1:0]  ResultSrcM;
    logic [31:0] ALUResultM;
    logic [31:0] PCPlus4M;
    logic [4:0]  RdM;
    logic [31:0] ReadDataM;
    logic        BusyM;
    logic        MisalignedM;

    int compared;
    int mismatched;

    memory_stage #(.word_width(32)) dut (
        .clk(clk), .reset(reset),
        .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
        .Funct3E(Funct3E), .ALUResultE(ALUResultE), .WriteDataE(WriteDataE),
        .PCPlus4E(PCPlus4E), .RdE(RdE),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_rdata(dmem_rdata),
        .dmem_ack(dmem_ack),
        .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .ALUResultM(ALUResultM),
        .PCPlus4M(PCPlus4M), .RdM(RdM), .ReadDataM(ReadDataM),
        .BusyM(BusyM), .MisalignedM(MisalignedM)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Pushes one instruction into M and plays the memory side for it, checking
    // every cycle it occupies M. dly = cycles the ack is withheld.
    task automatic issue(input string name, input logic rw, input logic [1:0] rs,
                         input logic mw, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rdat, input int dly);
        bit memop, is_load, mis, acc;
        int sz, dly_eff;
        longint unsigned span, v;
        logic [31:0] exp_rd, exp_wd;
        logic [3:0] exp_be;

        is_load = (rs == 2'b01);
        memop   = mw || is_load;
        sz      = 1 << f3[1:0];
        if (sz > 4) sz = 4;
        mis     = memop && ((a % sz) != 0);
        acc     = memop && !mis;
        dly_eff = acc ? dly : 0;
        span    = 64'd1 << (8 * sz);
        v       = (64'(a) * 0 + 64'(rdat >> (8 * (a % 4)))) % span;
        if (!f3[2] && v >= span / 2) v = v + 64'h1_0000_0000 - span;
        exp_rd  = v[31:0];
        exp_be  = 4'(((1 << sz) - 1) << (a % 4));
        if (sz == 1)      exp_wd = {24'b0, wd[7:0]} * 32'h0101_0101;
        else if (sz == 2) exp_wd = {16'b0, wd[15:0]} * 32'h0001_0001;
        else              exp_wd = wd;

        RegWriteE = rw; ResultSrcE = rs; MemWriteE = mw; Funct3E = f3;
        ALUResultE = a; WriteDataE = wd; PCPlus4E = a + 32'd4; RdE = a[8:4];
        @(posedge clk); #1;
        for (int c = 0; c <= dly_eff; c++) begin
            dmem_rdata = acc ? rdat : $urandom;
            dmem_ack   = acc ? (c == dly_eff) : 1'($urandom_range(0, 1));
            @(negedge clk);
            chk({name, ".req"},  32'(dmem_req),    32'(acc));
            chk({name, ".busy"}, 32'(BusyM),       32'(acc && c < dly_eff));
            chk({name, ".rw"},   32'(RegWriteM),   32'(rw && !mis && !(acc && c < dly_eff)));
            chk({name, ".mis"},  32'(MisalignedM), 32'(mis));
            chk({name, ".alu"},  ALUResultM,       a);
            chk({name, ".pc4"},  PCPlus4M,         a + 32'd4);
            chk({name, ".rd"},   32'(RdM),         32'(a[8:4]));
            chk({name, ".rs"},   32'(ResultSrcM),  32'(rs));
            if (acc) begin
                chk({name, ".addr"}, dmem_addr, a & ~32'd3);
                chk({name, ".we"},   32'(dmem_we), 32'(mw));
            end
            if (acc && mw) begin
                chk({name, ".be"},    32'(dmem_be), 32'(exp_be));
                chk({name, ".wdata"}, dmem_wdata,   exp_wd);
            end
            if (acc && is_load && c == dly_eff) chk({name, ".ldata"}, ReadDataM, exp_rd);
            if (!memop) begin
                chk({name, ".ldata0"}, ReadDataM,   32'd0);
                chk({name, ".be0"},    32'(dmem_be), 32'd0);
            end
            if (c < dly_eff) begin
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        compared = 0; mismatched = 0;
        reset = 1'b1; dmem_ack = 1'b0; dmem_rdata = '0;
        RegWriteE = 1'b1; ResultSrcE = 2'b01; MemWriteE = 1'b0; Funct3E = 3'b010;
        ALUResultE = 32'h40; WriteDataE = 32'h1; PCPlus4E = 32'h8; RdE = 5'd3;
        #12;
        chk("rst.req",  32'(dmem_req),  32'd0);
        chk("rst.busy", 32'(BusyM),     32'd0);
        chk("rst.rw",   32'(RegWriteM), 32'd0);
        chk("rst.alu",  ALUResultM,     32'd0);
        chk("rst.rd",   32'(RdM),       32'd0);
        @(negedge clk); reset = 1'b0;

        issue("sw",  1'b0, 2'b00, 1'b1, 3'b010, 32'h104, 32'hDEADBEEF, 32'h0, 2);
        issue("lb",  1'b1, 2'b01, 1'b0, 3'b000, 32'h203, 32'h0, 32'h80FF1234, 0);
        chk("lb.value", ReadDataM, 32'hFFFFFF80);
        issue("lhu", 1'b1, 2'b01, 1'b0, 3'b101, 32'h202, 32'h0, 32'h80FF1234, 1);
        chk("lhu.value", ReadDataM, 32'h000080FF);
        issue("sh",  1'b0, 2'b00, 1'b1, 3'b001, 32'h202, 32'h0000ABCD, 32'h0, 0);
        chk("sh.be", 32'(dmem_be), 32'hC);
        chk("sh.wdata", dmem_wdata, 32'hABCDABCD);
        issue("lwmis", 1'b1, 2'b01, 1'b0, 3'b010, 32'h101, 32'h0, 32'h12345678, 0);
        issue("after", 1'b1, 2'b00, 1'b0, 3'b000, 32'h55, 32'h0, 32'h0, 0);

        // Load left waiting on memory, then reset lands mid-access.
        RegWriteE = 1'b1; ResultSrcE = 2'b01; MemWriteE = 1'b0; Funct3E = 3'b010;
        ALUResultE = 32'h300; WriteDataE = 32'h0; PCPlus4E = 32'h304; RdE = 5'd7;
        @(posedge clk); #1; dmem_ack = 1'b0;
        @(negedge clk);
        chk("wait.busy0", 32'(BusyM), 32'd1);
        @(posedge clk); #1;
        chk("wait.busy1", 32'(BusyM), 32'd1);
        chk("wait.rw",    32'(RegWriteM), 32'd0);
        #2 reset = 1'b1; #1;
        chk("arst.req",  32'(dmem_req),  32'd0);
        chk("arst.busy", 32'(BusyM),     32'd0);
        chk("arst.rw",   32'(RegWriteM), 32'd0);
        chk("arst.alu",  ALUResultM,     32'd0);
        chk("arst.rd",   32'(RdM),       32'd0);
        @(posedge clk); #2 reset = 1'b0;
        issue("postrst", 1'b1, 2'b00, 1'b0, 3'b000, 32'h7A0, 32'h0, 32'h0, 0);

        for (int i = 0; i < 250; i++) begin
            int kind;
            logic [2:0] f3;
            logic [1:0] rs;
            logic mw;
            kind = $urandom_range(0, 3);
            f3 = 3'($urandom_range(0, 7));
            rs = 2'b00; mw = 1'b0;
            case (kind)
                1: begin
                    rs = 2'b01;
                    case ($urandom_range(0, 4))
                        0: f3 = 3'b000; 1: f3 = 3'b001; 2: f3 = 3'b010;
                        3: f3 = 3'b100; default: f3 = 3'b101;
                    endcase
                end
                2: begin mw = 1'b1; f3 = 3'($urandom_range(0, 2)); end
                3: rs = 2'b10;
                default: rs = 2'b00;
            endcase
            issue("rnd", 1'($urandom_range(0, 1)), rs, mw, f3, $urandom, $urandom,
                  $urandom, $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
